// File: rtl/strobe_gen_pkg.sv
// Shared types and constants for the multi-channel strobe divider.
// Holds the channel FSM encoding, reset values and the channel-index width helper.
package strobe_gen_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_HOLD = ST_HOLD
    } state_e;

    localparam state_e STATE_RST = S_IDLE;
    localparam logic   PULSE_RST = 1'b0;
    localparam logic   PEND_RST  = 1'b0;

    // Channel select width; a single channel still needs a 1-bit select port.
    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/strobe_gen_chan.sv
// One strobe divider channel: shadow config, IDLE/RUN/HOLD FSM, tick counter and
// burst counter. Outputs are registered single-cycle pulses.
module strobe_gen_chan
    import strobe_gen_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               strobe_in,
    input  logic               cfg_wr,
    input  logic [WIDTH-1:0]   cfg_rate,
    input  logic [WIDTH-1:0]   cfg_phase,
    input  logic [BURST_W-1:0] cfg_burst_len,
    output logic               strobe,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   sh_rate_q, sh_rate_d;
    logic [WIDTH-1:0]   sh_phase_q, sh_phase_d;
    logic [BURST_W-1:0] sh_burst_q, sh_burst_d;
    logic               pend_q, pend_d;
    logic [WIDTH-1:0]   act_rate_q, act_rate_d;
    logic [BURST_W-1:0] act_burst_q, act_burst_d;
    logic               strobe_q, strobe_d;
    logic               done_q, done_d;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        sh_rate_d   = sh_rate_q;
        sh_phase_d  = sh_phase_q;
        sh_burst_d  = sh_burst_q;
        pend_d      = pend_q;
        act_rate_d  = act_rate_q;
        act_burst_d = act_burst_q;
        strobe_d    = 1'b0;
        done_d      = 1'b0;

        if (!enable) begin
            state_d = S_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Load cycle: any strobe_in tick here is deliberately not counted.
                    state_d     = S_RUN;
                    count_d     = sh_phase_q;
                    rem_d       = sh_burst_q;
                    act_rate_d  = sh_rate_q;
                    act_burst_d = sh_burst_q;
                    pend_d      = 1'b0;
                end
                S_RUN: begin
                    if (strobe_in) begin
                        if (count_q != '0) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            strobe_d = 1'b1;
                            // pend_q reflects writes strictly before this cycle only.
                            if (pend_q) begin
                                count_d    = sh_rate_q;
                                act_rate_d = sh_rate_q;
                                pend_d     = 1'b0;
                            end else begin
                                count_d = act_rate_q;
                            end
                            if (act_burst_q != '0) begin
                                rem_d = rem_q - BURST_W'(1);
                                if (rem_q == BURST_W'(1)) begin
                                    done_d  = 1'b1;
                                    state_d = S_HOLD;
                                end
                            end
                        end
                    end
                end
                S_HOLD: begin
                    state_d = S_HOLD;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (cfg_wr) begin
            sh_rate_d  = cfg_rate;
            sh_phase_d = cfg_phase;
            sh_burst_d = cfg_burst_len;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STATE_RST;
            count_q     <= '0;
            rem_q       <= '0;
            sh_rate_q   <= '0;
            sh_phase_q  <= '0;
            sh_burst_q  <= '0;
            pend_q      <= PEND_RST;
            act_rate_q  <= '0;
            act_burst_q <= '0;
            strobe_q    <= PULSE_RST;
            done_q      <= PULSE_RST;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            sh_rate_q   <= sh_rate_d;
            sh_phase_q  <= sh_phase_d;
            sh_burst_q  <= sh_burst_d;
            pend_q      <= pend_d;
            act_rate_q  <= act_rate_d;
            act_burst_q <= act_burst_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
        end
    end

    assign strobe = strobe_q;
    assign done   = done_q;
    assign busy   = (state_q == S_RUN);

endmodule

// File: rtl/strobe_gen_multi.sv
// Multi-channel strobe divider: one strobe_gen_chan per channel sharing strobe_in,
// with the config write port decoded by cfg_ch (out-of-range selects are dropped).
module strobe_gen_multi
    import strobe_gen_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NUM_CH  = 4,
    parameter int BURST_W = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CH-1:0]               enable,
    input  logic                            strobe_in,
    input  logic                            cfg_wr,
    input  logic [ch_idx_w(NUM_CH)-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]                cfg_rate,
    input  logic [WIDTH-1:0]                cfg_phase,
    input  logic [BURST_W-1:0]              cfg_burst_len,
    output logic [NUM_CH-1:0]               strobe,
    output logic [NUM_CH-1:0]               busy,
    output logic [NUM_CH-1:0]               done
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] wr_sel;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign wr_sel[gi] = cfg_wr && (cfg_ch == CH_W'(gi));

        strobe_gen_chan #(
            .WIDTH   (WIDTH),
            .BURST_W (BURST_W)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .enable        (enable[gi]),
            .strobe_in     (strobe_in),
            .cfg_wr        (wr_sel[gi]),
            .cfg_rate      (cfg_rate),
            .cfg_phase     (cfg_phase),
            .cfg_burst_len (cfg_burst_len),
            .strobe        (strobe[gi]),
            .busy          (busy[gi]),
            .done          (done[gi])
        );
    end

endmodule

// File: tb/tb_strobe_gen_multi.sv
// Self-checking bench for strobe_gen_multi: table-driven channel runs plus hand
// sequences for rate change, phase offset / ignored select, and async reset.
module tb_strobe_gen_multi;

    localparam int NCH = 3;
    localparam int W   = 16;
    localparam int BW  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NCH-1:0]  enable;
    logic            strobe_in;
    logic            cfg_wr;
    logic [1:0]      cfg_ch;
    logic [W-1:0]    cfg_rate;
    logic [W-1:0]    cfg_phase;
    logic [BW-1:0]   cfg_burst_len;
    logic [NCH-1:0]  strobe;
    logic [NCH-1:0]  busy;
    logic [NCH-1:0]  done;

    always #5 clk = ~clk;

    strobe_gen_multi #(
        .WIDTH   (W),
        .NUM_CH  (NCH),
        .BURST_W (BW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .strobe_in     (strobe_in),
        .cfg_wr        (cfg_wr),
        .cfg_ch        (cfg_ch),
        .cfg_rate      (cfg_rate),
        .cfg_phase     (cfg_phase),
        .cfg_burst_len (cfg_burst_len),
        .strobe        (strobe),
        .busy          (busy),
        .done          (done)
    );

    typedef struct packed {
        logic [NCH-1:0] s;
        logic [NCH-1:0] b;
        logic [NCH-1:0] d;
    } exp_t;

    typedef struct {
        int ch;
        int rate;
        int phase;
        int burst;
        int per;      // strobe_in high every per clocks
        int ncyc;
        int wr;       // 0: reuse the previous configuration
        int exp_n;    // expected strobe count
        int exp_first;
    } vec_t;

    exp_t  sb_q[$];
    vec_t  vecs[7];
    int    n_cmp = 0;
    int    n_err = 0;
    string tag;

    task automatic check_now(input string nm, input exp_t e);
        n_cmp++;
        if (strobe !== e.s || busy !== e.b || done !== e.d) begin
            n_err++;
            $display("FAIL %s @%0t: strobe/busy/done=%b/%b/%b required %b/%b/%b",
                     nm, $time, strobe, busy, done, e.s, e.b, e.d);
        end
    endtask

    task automatic cyc(input logic [NCH-1:0] es, input logic [NCH-1:0] eb,
                       input logic [NCH-1:0] ed);
        exp_t e;
        e.s = es;
        e.b = eb;
        e.d = ed;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_now(tag, e);
        cfg_wr = 1'b0;
    endtask

    task automatic cfg(input int ch, input int rate, input int phase, input int burst);
        cfg_wr        = 1'b1;
        cfg_ch        = 2'(ch);
        cfg_rate      = W'(rate);
        cfg_phase     = W'(phase);
        cfg_burst_len = BW'(burst);
    endtask

    // Strobe after the t-th post-load tick: (phase+1)th tick, then every rate+1.
    function automatic bit hit(input int t, input int rate, input int phase);
        return (t >= phase + 1) && (((t - phase - 1) % (rate + 1)) == 0);
    endfunction

    function automatic bit rc_hit(input int c);
        return c inside {1, 9, 17, 20, 23, 26, 29, 37, 45};
    endfunction

    vec_t           v;
    int             t, nst, obs_n, obs_first;
    bit             run;
    logic [NCH-1:0] m, es, ed;
    exp_t           z;

    initial begin
        vecs[0] = '{ch:0, rate:3, phase:0, burst:0, per:1, ncyc:20, wr:1, exp_n:5, exp_first:1};
        vecs[1] = '{ch:0, rate:1, phase:0, burst:0, per:3, ncyc:30, wr:1, exp_n:5, exp_first:3};
        vecs[2] = '{ch:0, rate:2, phase:0, burst:3, per:1, ncyc:15, wr:1, exp_n:3, exp_first:1};
        vecs[3] = '{ch:0, rate:2, phase:0, burst:3, per:1, ncyc:15, wr:0, exp_n:3, exp_first:1};
        vecs[4] = '{ch:1, rate:0, phase:2, burst:0, per:1, ncyc:10, wr:1, exp_n:8, exp_first:3};
        vecs[5] = '{ch:2, rate:4, phase:6, burst:2, per:2, ncyc:40, wr:1, exp_n:2, exp_first:14};
        vecs[6] = '{ch:2, rate:0, phase:0, burst:1, per:1, ncyc:5,  wr:1, exp_n:1, exp_first:1};

        rst_n = 1'b0; enable = '0; strobe_in = 1'b0; cfg_wr = 1'b0;
        cfg_ch = '0; cfg_rate = '0; cfg_phase = '0; cfg_burst_len = '0;
        z = '0;
        #2;
        check_now("reset_state", z);
        tag = "reset_edge";
        cyc('0, '0, '0);
        #3 rst_n = 1'b1;

        // Table-driven single-channel runs
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            m = NCH'(1) << v.ch;
            tag = $sformatf("vec%0d_idle", i);
            enable = '0; strobe_in = 1'b0;
            cyc('0, '0, '0);
            if (v.wr != 0) begin
                tag = $sformatf("vec%0d_cfg", i);
                cfg(v.ch, v.rate, v.phase, v.burst);
                cyc('0, '0, '0);
            end
            tag = $sformatf("vec%0d_load", i);
            enable = m; strobe_in = 1'b1;
            cyc('0, m, '0);
            t = 0; nst = 0; obs_n = 0; obs_first = -1; run = 1'b1;
            for (int c = 1; c <= v.ncyc; c++) begin
                es = '0; ed = '0;
                strobe_in = ((c % v.per) == 0);
                if (strobe_in && run) begin
                    t++;
                    if (hit(t, v.rate, v.phase)) begin
                        es = m;
                        nst++;
                        if (v.burst != 0 && nst == v.burst) begin
                            ed = m;
                            run = 1'b0;
                        end
                    end
                end
                tag = $sformatf("vec%0d_c%0d", i, c);
                cyc(es, run ? m : NCH'(0), ed);
                if ((strobe & m) != '0) begin
                    obs_n++;
                    if (obs_first < 0) obs_first = c;
                end
            end
            n_cmp++;
            if (obs_n != v.exp_n || obs_first != v.exp_first) begin
                n_err++;
                $display("FAIL vec%0d_count: %0d strobes first c%0d, required %0d first c%0d",
                         i, obs_n, obs_first, v.exp_n, v.exp_first);
            end
            $display("vec%0d ch%0d rate=%0d phase=%0d burst=%0d per=%0d: %0d strobes, first c%0d",
                     i, v.ch, v.rate, v.phase, v.burst, v.per, obs_n, obs_first);
        end

        // Rate change: write in the wrap cycle (c=9) and mid-period (c=27)
        tag = "rc_idle";
        enable = '0; strobe_in = 1'b0;
        cyc('0, '0, '0);
        tag = "rc_cfg";
        cfg(0, 7, 0, 0);
        cyc('0, '0, '0);
        tag = "rc_load";
        enable = 3'b001; strobe_in = 1'b1;
        cyc('0, 3'b001, '0);
        for (int c = 1; c <= 46; c++) begin
            if (c == 9)  cfg(0, 2, 0, 0);
            if (c == 27) cfg(0, 7, 0, 0);
            tag = $sformatf("rc_c%0d", c);
            cyc(rc_hit(c) ? 3'b001 : 3'b000, 3'b001, '0);
        end
        $display("rate change sequence done");

        // Phase offset, ignored select, cross-channel write during a wrap
        tag = "ph_idle";
        enable = '0; strobe_in = 1'b0;
        cyc('0, '0, '0);
        tag = "ph_cfg0"; cfg(0, 3, 0, 0); cyc('0, '0, '0);
        tag = "ph_cfg1"; cfg(1, 3, 2, 0); cyc('0, '0, '0);
        tag = "ph_cfg_bad"; cfg(3, 0, 0, 1); cyc('0, '0, '0);
        tag = "ph_load";
        enable = 3'b011; strobe_in = 1'b1;
        cyc('0, 3'b011, '0);
        for (int c = 1; c <= 16; c++) begin
            if (c == 5) cfg(2, 0, 0, 0);
            es = '0;
            es[0] = hit(c, 3, 0);
            es[1] = hit(c, 3, 2);
            tag = $sformatf("ph_c%0d", c);
            cyc(es, 3'b011, '0);
        end
        $display("phase offset sequence done");

        // Async reset mid-burst
        tag = "ar_idle";
        enable = '0; strobe_in = 1'b0;
        cyc('0, '0, '0);
        tag = "ar_cfg"; cfg(0, 2, 0, 5); cyc('0, '0, '0);
        tag = "ar_load";
        enable = 3'b001; strobe_in = 1'b1;
        cyc('0, 3'b001, '0);
        for (int c = 1; c <= 4; c++) begin
            tag = $sformatf("ar_c%0d", c);
            cyc((c == 1 || c == 4) ? 3'b001 : 3'b000, 3'b001, '0);
        end
        #3 rst_n = 1'b0;
        #1;
        check_now("ar_async", z);
        tag = "ar_hold";
        cyc('0, '0, '0);
        #4 rst_n = 1'b1;
        tag = "ar_reload";
        cyc('0, 3'b001, '0);
        for (int c = 1; c <= 8; c++) begin
            tag = $sformatf("ar_post_c%0d", c);
            cyc(3'b001, 3'b001, '0);
        end
        $display("async reset sequence done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
